cv_xpulp_alu_decoder: RTL and testbench
=======================================

Name: cv_xpulp_alu_decoder

Overview:
- Registered decoder for the CV32E40P custom ALU and immediate-branch instructions (opcodes 0x2B, 0x5B, 0x0B).
- Takes a 32-bit instruction word over a valid/ready handshake. Produces the internal ALU operator (alu_opcode_e), operand addresses, immediates and control flags, plus an illegal flag.
- Sits between the instruction stream and the ALU model/scoreboard: it is the decode end of the same encoding the instruction generator produces.

Parameters:
- CNT_W, 16, width of the saturating decoded/illegal statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  drop held output and clear the stage
- in_valid_i  in  1  instruction valid
- in_ready_o  out  1  stage can accept
- in_instr_i  in  32  instruction word
- out_valid_o  out  1  decoded result valid
- out_ready_i  in  1  consumer accepts
- alu_op_o  out  7  alu_opcode_e operator
- rs1_o / rs2_o / rd_o  out  5 each  instr[19:15] / [24:20] / [11:7]
- uses_rs2_o  out  1  rs2 is a register source
- rd_is_src_o  out  1  rd is also read (insert, addN/subN families)
- imm_a_o  out  5  instr[29:25] (Is3 / shift amount)
- imm_b_o  out  5  instr[24:20] (Is2 / clip bound / Luimm)
- ext_half_o  out  1  1 = half-word extension, 0 = byte
- is_branch_o  out  1  cv.beqimm / cv.bneimm
- br_imm_o  out  32  instr[24:20] sign-extended
- br_off_o  out  13  B-type offset {i[31],i[7],i[30:25],i[11:8],0}
- illegal_o  out  1  unsupported encoding
- cnt_decoded_o  out  CNT_W  accepted instructions
- cnt_illegal_o  out  CNT_W  accepted illegal instructions

Behaviour:
- Reset: out_valid_o=0; all payload outputs 0; alu_op_o=ALU_ADD; counters 0.
- Handshake: in_ready_o = !out_valid_o || out_ready_i (combinational, no bubble). An accept is in_valid_i && in_ready_o; the result appears on the next cycle, so latency is 1 and throughput is 1/cycle. Output is held stable while out_valid_o && !out_ready_i.
- flush_i: in_ready_o=0 that cycle; out_valid_o cleared next cycle; no accept, no counter update. Flush has priority over accept and over out_ready_i.
- Opcode 0x2B, funct3=011, keyed on funct7:
  - EXTRACTR→BEXT, EXTRACTUR→BEXTU, INSERTR→BINS (rd_is_src), BCLRR→BCLR, BSETR→BSET, ROR→ROR.
  - FF1/FL1/CLB/CNT/ABS→same-named op.
  - SLE→SLETS, SLEU→SLETU, MIN/MINU/MAX/MAXU→same.
  - EXTHS/EXTBS→EXTS, EXTHZ/EXTBZ→EXT, ext_half per H/B.
  - CLIP→CLIP, CLIPU→CLIPU (imm_b bound, uses_rs2=0); CLIPR→CLIP, CLIPUR→CLIPU (uses_rs2=1).
  - ADDNR/ADDUNR/ADDRNR/ADDURNR→ADD/ADDU/ADDR/ADDUR; SUBNR..SUBURNR→SUB/SUBU/SUBR/SUBUR. All eight set rd_is_src.
  - All others in this group set uses_rs2=1, except the unary ops: FF1, FL1, CLB, CNT, ABS, EXT*.
- Opcode 0x5B, keyed on {instr[31:30],funct3}: EXTRACT→BEXT, EXTRACTU→BEXTU, INSERT→BINS (rd_is_src), BCLR→BCLR, BSET→BSET, BITREV→BREV, ADDN..ADDURN→ADD/ADDU/ADDR/ADDUR, SUBN..SUBURN→SUB/SUBU/SUBR/SUBUR. uses_rs2=0 for all.
- Opcode 0x0B: funct3 110→ALU_EQ, 111→ALU_NE; is_branch=1; uses_rs2=0.
- Illegal, with alu_op=ALU_ADD and all flags 0 except illegal_o:
  - any other opcode/funct combination;
  - a unary 0x2B op with rs2 field ≠ 0;
  - {f2,funct3}=10_001 under 0x5B;
  - funct3 other than 110/111 under 0x0B.
  - Raw fields (rs1/rs2/rd/imm_a/imm_b/br_*) are always passed through.
- Counters: on accept, cnt_decoded increments; cnt_illegal also increments if illegal. Both saturate at all-ones.
- Reset mid-transfer: held result is discarded asynchronously; no partial state survives.

Decomposition:
- Extend risc_pkg with:
  - a packed struct dec_out_t holding all payload fields;
  - a localparam default-decode constant;
  - a pure function decode_instr(logic[31:0]) returning dec_out_t, reused by the scoreboard reference model.
- RTL: the decode function plus one pipeline register and the counters. No sub-module needed.

Test Plan:
- cv.extractur encoding (0x2B, funct7 0011001, funct3 011), out_ready=1 → next cycle alu_op=ALU_BEXTU (0101001), uses_rs2=1, illegal=0, cnt_decoded=1.
- cv.addrn imm (0x5B, f2=10, funct3=010, Is3=5) → ALU_ADDR (0011100), imm_a=5, rd_is_src=1, uses_rs2=0.
- cv.bneimm with instr[24:20]=5'b10000 → ALU_NE, is_branch=1, br_imm=0xFFFFFFF0, correct br_off.
- cv.ff1 with rs2=3 → illegal=1, alu_op=ALU_ADD, cnt_illegal=1. Opcode 0x33 → illegal.
- Backpressure: out_ready=0 for 4 cycles with in_valid held → outputs stable, in_ready=0, exactly one count. Then back-to-back stream at out_ready=1 → one result per cycle.
- flush_i with in_valid=1 while output held → out_valid=0 next cycle, counters unchanged. Force counters to all-ones → no wrap.

Source files
------------

// File: rtl/cv_xpulp_alu_decoder_pkg.sv
// Shared types and the pure decode function for the XPULP ALU decoder.
// Covers custom opcodes 0x2B (ALU reg), 0x5B (ALU imm), 0x0B (imm branch).
package cv_xpulp_alu_decoder_pkg;

  typedef enum logic [6:0] {
    ALU_ADD   = 7'b0011000,
    ALU_SUB   = 7'b0011001,
    ALU_ADDU  = 7'b0011010,
    ALU_SUBU  = 7'b0011011,
    ALU_ADDR  = 7'b0011100,
    ALU_SUBR  = 7'b0011101,
    ALU_ADDUR = 7'b0011110,
    ALU_SUBUR = 7'b0011111,
    ALU_ROR   = 7'b0100110,
    ALU_BEXT  = 7'b0101000,
    ALU_BEXTU = 7'b0101001,
    ALU_BINS  = 7'b0101010,
    ALU_BCLR  = 7'b0101011,
    ALU_BSET  = 7'b0101100,
    ALU_BREV  = 7'b1001001,
    ALU_FF1   = 7'b0110110,
    ALU_FL1   = 7'b0110111,
    ALU_CNT   = 7'b0110100,
    ALU_CLB   = 7'b0110101,
    ALU_EXTS  = 7'b0111110,
    ALU_EXT   = 7'b0111111,
    ALU_EQ    = 7'b0001100,
    ALU_NE    = 7'b0001101,
    ALU_SLETS = 7'b0000110,
    ALU_SLETU = 7'b0000111,
    ALU_ABS   = 7'b0010100,
    ALU_CLIP  = 7'b0010110,
    ALU_CLIPU = 7'b0010111,
    ALU_MIN   = 7'b0010000,
    ALU_MINU  = 7'b0010001,
    ALU_MAX   = 7'b0010010,
    ALU_MAXU  = 7'b0010011
  } alu_opcode_e;

  localparam logic [6:0] OPC_BRIMM = 7'h0B;
  localparam logic [6:0] OPC_ALUR  = 7'h2B;
  localparam logic [6:0] OPC_ALUI  = 7'h5B;

  typedef struct packed {
    alu_opcode_e alu_op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        uses_rs2;
    logic        rd_is_src;
    logic [4:0]  imm_a;
    logic [4:0]  imm_b;
    logic        ext_half;
    logic        is_branch;
    logic [31:0] br_imm;
    logic [12:0] br_off;
    logic        illegal;
  } dec_out_t;

  localparam dec_out_t DEC_DEFAULT = '{
    alu_op:    ALU_ADD,
    rs1:       5'd0,
    rs2:       5'd0,
    rd:        5'd0,
    uses_rs2:  1'b0,
    rd_is_src: 1'b0,
    imm_a:     5'd0,
    imm_b:     5'd0,
    ext_half:  1'b0,
    is_branch: 1'b0,
    br_imm:    32'd0,
    br_off:    13'd0,
    illegal:   1'b0
  };

  function automatic dec_out_t decode_instr(
    input logic [31:0] i
  );
    dec_out_t d;
    logic     unary;
    d          = DEC_DEFAULT;
    unary      = 1'b0;
    d.rs1      = i[19:15];
    d.rs2      = i[24:20];
    d.rd       = i[11:7];
    d.imm_a    = i[29:25];
    d.imm_b    = i[24:20];
    d.br_imm   = {{27{i[24]}}, i[24:20]};
    d.br_off   = {i[31], i[7], i[30:25],
                  i[11:8], 1'b0};
    unique case (i[6:0])
      OPC_ALUR: begin
        d.uses_rs2 = 1'b1;
        if (i[14:12] != 3'b011) begin
          d.illegal = 1'b1;
        end else begin
          unique case (i[31:25])
            7'b0011000: d.alu_op = ALU_BEXT;
            7'b0011001: d.alu_op = ALU_BEXTU;
            7'b0011010: begin
              d.alu_op    = ALU_BINS;
              d.rd_is_src = 1'b1;
            end
            7'b0011100: d.alu_op = ALU_BCLR;
            7'b0011101: d.alu_op = ALU_BSET;
            7'b0100000: d.alu_op = ALU_ROR;
            7'b0100001: begin
              d.alu_op = ALU_FF1;
              unary    = 1'b1;
            end
            7'b0100010: begin
              d.alu_op = ALU_FL1;
              unary    = 1'b1;
            end
            7'b0100011: begin
              d.alu_op = ALU_CLB;
              unary    = 1'b1;
            end
            7'b0100100: begin
              d.alu_op = ALU_CNT;
              unary    = 1'b1;
            end
            7'b0101000: begin
              d.alu_op = ALU_ABS;
              unary    = 1'b1;
            end
            7'b0101001: d.alu_op = ALU_SLETS;
            7'b0101010: d.alu_op = ALU_SLETU;
            7'b0101011: d.alu_op = ALU_MIN;
            7'b0101100: d.alu_op = ALU_MINU;
            7'b0101101: d.alu_op = ALU_MAX;
            7'b0101110: d.alu_op = ALU_MAXU;
            7'b0110000, 7'b0110010: begin
              d.alu_op   = ALU_EXTS;
              d.ext_half = ~i[26];
              unary      = 1'b1;
            end
            7'b0110001, 7'b0110011: begin
              d.alu_op   = ALU_EXT;
              d.ext_half = ~i[26];
              unary      = 1'b1;
            end
            7'b0111000: begin
              d.alu_op   = ALU_CLIP;
              d.uses_rs2 = 1'b0;
            end
            7'b0111001: begin
              d.alu_op   = ALU_CLIPU;
              d.uses_rs2 = 1'b0;
            end
            7'b0111010: d.alu_op = ALU_CLIP;
            7'b0111011: d.alu_op = ALU_CLIPU;
            7'b1000000: d.alu_op = ALU_ADD;
            7'b1000001: d.alu_op = ALU_ADDU;
            7'b1000010: d.alu_op = ALU_ADDR;
            7'b1000011: d.alu_op = ALU_ADDUR;
            7'b1000100: d.alu_op = ALU_SUB;
            7'b1000101: d.alu_op = ALU_SUBU;
            7'b1000110: d.alu_op = ALU_SUBR;
            7'b1000111: d.alu_op = ALU_SUBUR;
            default:    d.illegal = 1'b1;
          endcase
          if (i[31:28] == 4'b1000) begin
            d.rd_is_src = 1'b1;
          end
        end
      end
      OPC_ALUI: begin
        unique case ({i[31:30], i[14:12]})
          5'b00_000: d.alu_op = ALU_BEXT;
          5'b01_000: d.alu_op = ALU_BEXTU;
          5'b10_000: begin
            d.alu_op    = ALU_BINS;
            d.rd_is_src = 1'b1;
          end
          5'b00_001: d.alu_op = ALU_BCLR;
          5'b01_001: d.alu_op = ALU_BSET;
          5'b11_001: d.alu_op = ALU_BREV;
          5'b00_010: d.alu_op = ALU_ADD;
          5'b01_010: d.alu_op = ALU_ADDU;
          5'b10_010: d.alu_op = ALU_ADDR;
          5'b11_010: d.alu_op = ALU_ADDUR;
          5'b00_011: d.alu_op = ALU_SUB;
          5'b01_011: d.alu_op = ALU_SUBU;
          5'b10_011: d.alu_op = ALU_SUBR;
          5'b11_011: d.alu_op = ALU_SUBUR;
          default:   d.illegal = 1'b1;
        endcase
        if (i[13]) begin
          d.rd_is_src = 1'b1;
        end
      end
      OPC_BRIMM: begin
        d.is_branch = 1'b1;
        unique case (i[14:12])
          3'b110:  d.alu_op = ALU_EQ;
          3'b111:  d.alu_op = ALU_NE;
          default: d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    if (unary) begin
      d.uses_rs2 = 1'b0;
      if (i[24:20] != 5'd0) begin
        d.illegal = 1'b1;
      end
    end
    if (d.illegal) begin
      d.alu_op    = ALU_ADD;
      d.uses_rs2  = 1'b0;
      d.rd_is_src = 1'b0;
      d.ext_half  = 1'b0;
      d.is_branch = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/cv_xpulp_alu_decoder_if.sv
// Instruction-in / decoded-result-out bundle of the XPULP ALU decoder.
// Master drives instructions and accepts results; slave is the decoder.
interface cv_xpulp_alu_decoder_if;
  import cv_xpulp_alu_decoder_pkg::*;

  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_instr_i;
  logic        out_valid_o;
  logic        out_ready_i;
  alu_opcode_e alu_op_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [4:0]  rd_o;
  logic        uses_rs2_o;
  logic        rd_is_src_o;
  logic [4:0]  imm_a_o;
  logic [4:0]  imm_b_o;
  logic        ext_half_o;
  logic        is_branch_o;
  logic [31:0] br_imm_o;
  logic [12:0] br_off_o;
  logic        illegal_o;

  modport master (
    output in_valid_i, in_instr_i, out_ready_i,
    input  in_ready_o, out_valid_o, alu_op_o,
    input  rs1_o, rs2_o, rd_o, uses_rs2_o,
    input  rd_is_src_o, imm_a_o, imm_b_o,
    input  ext_half_o, is_branch_o, br_imm_o,
    input  br_off_o, illegal_o
  );

  modport slave (
    input  in_valid_i, in_instr_i, out_ready_i,
    output in_ready_o, out_valid_o, alu_op_o,
    output rs1_o, rs2_o, rd_o, uses_rs2_o,
    output rd_is_src_o, imm_a_o, imm_b_o,
    output ext_half_o, is_branch_o, br_imm_o,
    output br_off_o, illegal_o
  );

endinterface

// File: rtl/cv_xpulp_alu_decoder.sv
// Registered XPULP ALU / immediate-branch decoder stage.
// One-deep skid-free output register plus saturating statistics.
module cv_xpulp_alu_decoder
  import cv_xpulp_alu_decoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  cv_xpulp_alu_decoder_if.slave bus,
  output logic [CNT_W-1:0]      cnt_decoded_o,
  output logic [CNT_W-1:0]      cnt_illegal_o
);

  logic             out_valid_q;
  logic             accept;
  dec_out_t         dec_d;
  dec_out_t         dec_q;
  logic [CNT_W-1:0] cnt_dec_q;
  logic [CNT_W-1:0] cnt_ill_q;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  assign bus.in_ready_o = !flush_i &&
                          (!out_valid_q || bus.out_ready_i);
  assign accept = bus.in_valid_i && bus.in_ready_o;

  // Pure combinational decode of the presented word
  always_comb dec_d = decode_instr(bus.in_instr_i);

  // Result register: load on accept, drop on drain or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dec_q       <= DEC_DEFAULT;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      dec_q       <= dec_d;
    end else if (bus.out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  // Saturating accept / illegal statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_dec_q <= '0;
      cnt_ill_q <= '0;
    end else if (accept) begin
      if (cnt_dec_q != CNT_MAX) begin
        cnt_dec_q <= cnt_dec_q + CNT_ONE;
      end
      if (dec_d.illegal && cnt_ill_q != CNT_MAX) begin
        cnt_ill_q <= cnt_ill_q + CNT_ONE;
      end
    end
  end

  assign bus.out_valid_o = out_valid_q;
  assign bus.alu_op_o    = dec_q.alu_op;
  assign bus.rs1_o       = dec_q.rs1;
  assign bus.rs2_o       = dec_q.rs2;
  assign bus.rd_o        = dec_q.rd;
  assign bus.uses_rs2_o  = dec_q.uses_rs2;
  assign bus.rd_is_src_o = dec_q.rd_is_src;
  assign bus.imm_a_o     = dec_q.imm_a;
  assign bus.imm_b_o     = dec_q.imm_b;
  assign bus.ext_half_o  = dec_q.ext_half;
  assign bus.is_branch_o = dec_q.is_branch;
  assign bus.br_imm_o    = dec_q.br_imm;
  assign bus.br_off_o    = dec_q.br_off;
  assign bus.illegal_o   = dec_q.illegal;
  assign cnt_decoded_o   = cnt_dec_q;
  assign cnt_illegal_o   = cnt_ill_q;

endmodule

// File: tb/tb_cv_xpulp_alu_decoder.sv
// Scoreboard bench for the XPULP ALU decoder.
// Directed vectors with hand-derived expected decodes.
module tb_cv_xpulp_alu_decoder;
  import cv_xpulp_alu_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_i;
  logic flush2;
  logic [15:0] cnt_dec;
  logic [15:0] cnt_ill;
  logic [1:0]  cnt2_dec;
  logic [1:0]  cnt2_ill;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_dec = 0;
  int exp_ill = 0;

  dec_out_t exp_q[$];
  string    nm_q[$];
  dec_out_t act;

  cv_xpulp_alu_decoder_if bus ();
  cv_xpulp_alu_decoder_if bus2 ();

  cv_xpulp_alu_decoder #(.CNT_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush_i),
    .bus           (bus.slave),
    .cnt_decoded_o (cnt_dec),
    .cnt_illegal_o (cnt_ill)
  );

  cv_xpulp_alu_decoder #(.CNT_W(2)) dut2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (flush2),
    .bus           (bus2.slave),
    .cnt_decoded_o (cnt2_dec),
    .cnt_illegal_o (cnt2_ill)
  );

  always #5 clk = ~clk;

  always_comb begin
    act           = DEC_DEFAULT;
    act.alu_op    = bus.alu_op_o;
    act.rs1       = bus.rs1_o;
    act.rs2       = bus.rs2_o;
    act.rd        = bus.rd_o;
    act.uses_rs2  = bus.uses_rs2_o;
    act.rd_is_src = bus.rd_is_src_o;
    act.imm_a     = bus.imm_a_o;
    act.imm_b     = bus.imm_b_o;
    act.ext_half  = bus.ext_half_o;
    act.is_branch = bus.is_branch_o;
    act.br_imm    = bus.br_imm_o;
    act.br_off    = bus.br_off_o;
    act.illegal   = bus.illegal_o;
  end

  task automatic chk(input string nm,
                     input logic [127:0] a,
                     input logic [127:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  function automatic dec_out_t mk(
    input alu_opcode_e op,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [4:0] rd, input logic u2,
    input logic rds, input logic [4:0] ia,
    input logic [4:0] ib, input logic eh,
    input logic br, input logic [31:0] bi,
    input logic [12:0] bo, input logic ill);
    dec_out_t d;
    d.alu_op = op;  d.rs1 = rs1; d.rs2 = rs2;
    d.rd = rd;      d.uses_rs2 = u2;
    d.rd_is_src = rds; d.imm_a = ia;
    d.imm_b = ib;   d.ext_half = eh;
    d.is_branch = br; d.br_imm = bi;
    d.br_off = bo;  d.illegal = ill;
    return d;
  endfunction

  // Monitor: pop and compare on every output transfer
  always @(negedge clk) begin
    if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %0h want none",
                 act);
      end else begin
        dec_out_t e;
        string nm;
        e  = exp_q.pop_front();
        nm = nm_q.pop_front();
        chk(nm, 128'(act), 128'(e));
      end
    end
  end

  task automatic send(input string nm,
                      input logic [31:0] ins,
                      input dec_out_t e,
                      input bit must_go);
    int w;
    w = 0;
    bus.in_valid_i = 1'b1;
    bus.in_instr_i = ins;
    @(negedge clk);
    while (!bus.in_ready_o && w < 20) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready_o) begin
      chk({nm, "_timeout"}, 128'(0), 128'(1));
    end else begin
      exp_q.push_back(e);
      nm_q.push_back(nm);
      exp_dec++;
      if (e.illegal) exp_ill++;
    end
    if (must_go) chk({nm, "_stall"}, 128'(w), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  localparam logic [31:0] I_EXTUR =
    {7'b0011001, 5'd2, 5'd1, 3'b011, 5'd3, 7'h2B};
  localparam logic [31:0] I_ADDRN =
    {2'b10, 5'd5, 5'd4, 5'd6, 3'b010, 5'd7, 7'h5B};
  localparam logic [31:0] I_BNEI =
    {7'b1000010, 5'b10000, 5'd8, 3'b111, 5'd8, 7'h0B};
  localparam logic [31:0] I_FF1BAD =
    {7'b0100001, 5'd3, 5'd1, 3'b011, 5'd2, 7'h2B};
  localparam logic [31:0] I_OP33 = 32'h0000_0033;
  localparam logic [31:0] I_FF1 =
    {7'b0100001, 5'd0, 5'd9, 3'b011, 5'd0, 7'h2B};
  localparam logic [31:0] I_EXTHZ =
    {7'b0110001, 5'd0, 5'd1, 3'b011, 5'd0, 7'h2B};
  localparam logic [31:0] I_CLIP =
    {7'b0111000, 5'd7, 5'd1, 3'b011, 5'd0, 7'h2B};
  localparam logic [31:0] I_CLIPUR =
    {7'b0111011, 5'd7, 5'd1, 3'b011, 5'd0, 7'h2B};
  localparam logic [31:0] I_SUBRNR =
    {7'b1000110, 5'd2, 5'd1, 3'b011, 5'd0, 7'h2B};
  localparam logic [31:0] I_5BBAD =
    {2'b10, 5'd0, 5'd0, 5'd1, 3'b001, 5'd0, 7'h5B};
  localparam logic [31:0] I_0BBAD =
    {7'd0, 5'd0, 5'd1, 3'b000, 5'd0, 7'h0B};
  localparam logic [31:0] I_BEQI =
    {7'd0, 5'b00101, 5'd1, 3'b110, 5'd0, 7'h0B};
  localparam logic [31:0] I_BREV =
    {2'b11, 5'd3, 5'd2, 5'd1, 3'b001, 5'd0, 7'h5B};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    dec_out_t e_extur, e_addrn, e_bnei, e_ff1bad;
    dec_out_t e_op33, e_ff1, e_exthz, e_clip;
    dec_out_t e_clipur, e_subrnr, e_5bbad, e_0bbad;
    dec_out_t e_beqi, e_brev;

    e_extur  = mk(ALU_BEXTU, 1, 2, 3, 1, 0, 25, 2,
                  0, 0, 32'd2, 13'h0B22, 0);
    e_addrn  = mk(ALU_ADDR, 6, 4, 7, 0, 1, 5, 4,
                  0, 0, 32'd4, 13'h18A6, 0);
    e_bnei   = mk(ALU_NE, 8, 16, 8, 0, 0, 2, 16,
                  0, 1, 32'hFFFF_FFF0, 13'h1048, 0);
    e_ff1bad = mk(ALU_ADD, 1, 3, 2, 0, 0, 1, 3,
                  0, 0, 32'd3, 13'h0422, 1);
    e_op33   = mk(ALU_ADD, 0, 0, 0, 0, 0, 0, 0,
                  0, 0, 32'd0, 13'h0000, 1);
    e_ff1    = mk(ALU_FF1, 9, 0, 0, 0, 0, 1, 0,
                  0, 0, 32'd0, 13'h0420, 0);
    e_exthz  = mk(ALU_EXT, 1, 0, 0, 0, 0, 17, 0,
                  1, 0, 32'd0, 13'h0620, 0);
    e_clip   = mk(ALU_CLIP, 1, 7, 0, 0, 0, 24, 7,
                  0, 0, 32'd7, 13'h0700, 0);
    e_clipur = mk(ALU_CLIPU, 1, 7, 0, 1, 0, 27, 7,
                  0, 0, 32'd7, 13'h0760, 0);
    e_subrnr = mk(ALU_SUBR, 1, 2, 0, 1, 1, 6, 2,
                  0, 0, 32'd2, 13'h10C0, 0);
    e_5bbad  = mk(ALU_ADD, 1, 0, 0, 0, 0, 0, 0,
                  0, 0, 32'd0, 13'h1000, 1);
    e_0bbad  = mk(ALU_ADD, 1, 0, 0, 0, 0, 0, 0,
                  0, 0, 32'd0, 13'h0000, 1);
    e_beqi   = mk(ALU_EQ, 1, 5, 0, 0, 0, 0, 5,
                  0, 1, 32'd5, 13'h0000, 0);
    e_brev   = mk(ALU_BREV, 1, 2, 0, 0, 0, 3, 2,
                  0, 0, 32'd2, 13'h1460, 0);

    rst_n           = 1'b0;
    flush_i         = 1'b0;
    flush2          = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_instr_i  = 32'd0;
    bus.out_ready_i = 1'b1;
    bus2.in_valid_i  = 1'b0;
    bus2.in_instr_i  = 32'd0;
    bus2.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 128'(bus.out_valid_o), 128'(0));
    chk("rst_payload", 128'(act), 128'(DEC_DEFAULT));
    chk("rst_alu_add", 128'(bus.alu_op_o),
        128'(7'b0011000));
    chk("rst_cnt_dec", 128'(cnt_dec), 128'(0));
    chk("rst_cnt_ill", 128'(cnt_ill), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_after_rst", 128'(bus.in_ready_o), 128'(1));

    send("extractur", I_EXTUR, e_extur, 1);
    chk("cnt_dec_1", 128'(cnt_dec), 128'(1));
    chk("cnt_ill_0", 128'(cnt_ill), 128'(0));
    send("addrn", I_ADDRN, e_addrn, 1);
    send("bneimm", I_BNEI, e_bnei, 1);
    send("ff1_rs2", I_FF1BAD, e_ff1bad, 1);
    chk("cnt_ill_1", 128'(cnt_ill), 128'(1));
    send("op33", I_OP33, e_op33, 1);
    send("ff1", I_FF1, e_ff1, 1);
    send("exthz", I_EXTHZ, e_exthz, 1);
    send("clip", I_CLIP, e_clip, 1);
    send("clipur", I_CLIPUR, e_clipur, 1);
    send("subrnr", I_SUBRNR, e_subrnr, 1);
    send("5b_10_001", I_5BBAD, e_5bbad, 1);
    send("0b_f3_000", I_0BBAD, e_0bbad, 1);
    send("beqimm", I_BEQI, e_beqi, 1);
    send("bitrev", I_BREV, e_brev, 1);
    idle(2);
    chk("stream_drained", 128'(exp_q.size()), 128'(0));
    chk("cnt_dec_14", 128'(cnt_dec), 128'(14));
    chk("cnt_ill_4", 128'(cnt_ill), 128'(4));

    bus.out_ready_i = 1'b0;
    send("bp_held", I_EXTUR, e_extur, 1);
    bus.in_valid_i = 1'b1;
    bus.in_instr_i = I_ADDRN;
    repeat (4) begin
      @(negedge clk);
      chk("bp_ready", 128'(bus.in_ready_o), 128'(0));
      chk("bp_valid", 128'(bus.out_valid_o), 128'(1));
      chk("bp_stable", 128'(act), 128'(e_extur));
      chk("bp_count", 128'(cnt_dec), 128'(15));
      @(posedge clk);
      #1;
    end
    bus.out_ready_i = 1'b1;
    send("bp_next", I_ADDRN, e_addrn, 1);
    send("b2b_a", I_BNEI, e_bnei, 1);
    send("b2b_b", I_CLIP, e_clip, 1);
    idle(2);
    chk("bp_cnt_dec", 128'(cnt_dec), 128'(exp_dec));

    bus.out_ready_i = 1'b0;
    send("fl_held", I_BNEI, e_bnei, 1);
    flush_i        = 1'b1;
    bus.in_valid_i = 1'b1;
    bus.in_instr_i = I_FF1BAD;
    @(negedge clk);
    chk("flush_ready", 128'(bus.in_ready_o), 128'(0));
    @(posedge clk);
    #1;
    flush_i        = 1'b0;
    bus.in_valid_i = 1'b0;
    void'(exp_q.pop_back());
    void'(nm_q.pop_back());
    @(negedge clk);
    chk("flush_valid", 128'(bus.out_valid_o), 128'(0));
    chk("flush_cnt_dec", 128'(cnt_dec), 128'(exp_dec));
    chk("flush_cnt_ill", 128'(cnt_ill), 128'(exp_ill));
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b1;

    bus2.in_valid_i = 1'b1;
    bus2.in_instr_i = I_OP33;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus2.in_instr_i = I_EXTUR;
    @(posedge clk);
    #1;
    chk("sat_dec_3", 128'(cnt2_dec), 128'(3));
    chk("sat_ill_2", 128'(cnt2_ill), 128'(2));
    bus2.in_instr_i = I_OP33;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus2.in_valid_i = 1'b0;
    chk("sat_dec_hold", 128'(cnt2_dec), 128'(3));
    chk("sat_ill_hold", 128'(cnt2_ill), 128'(3));

    bus.out_ready_i = 1'b0;
    send("rst_held", I_BEQI, e_beqi, 1);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(bus.out_valid_o), 128'(0));
    chk("arst_payload", 128'(act), 128'(DEC_DEFAULT));
    chk("arst_cnt_dec", 128'(cnt_dec), 128'(0));
    void'(exp_q.pop_back());
    void'(nm_q.pop_back());
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    idle(2);
    chk("final_queue", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
